seq_adder: RTL and testbench

- Parametrised multi-cycle add/subtract unit; successor to the processor's 8-bit combinational adder.
- Processes DIGIT bits per clock, LSB first, over a WIDTH-bit operand pair.
- Uses a start/busy/done handshake and produces N, Z, C and V flags.
- Lets the datapath trade latency for area at wider widths. The multicycle controller waits on done.

---
 rtl/seq_adder_pkg.sv | 27 ++
 rtl/seq_adder_digit.sv | 27 ++
 rtl/seq_adder.sv | 143 ++++++++++++++
 tb/tb_seq_adder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the multi-cycle add/subtract unit.
// Holds the FSM encoding, digit-count helper and signed-extreme generators.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SAT_MAXW = 64;
  localparam logic [SAT_MAXW-1:0] SAT_ONES = '1;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Signed extremes for a given width, right-aligned in a SAT_MAXW-bit word.
  function automatic logic [SAT_MAXW-1:0] sat_pos(input int width);
    return SAT_ONES >> (SAT_MAXW - width + 1);
  endfunction

  function automatic logic [SAT_MAXW-1:0] sat_neg(input int width);
    return {{(SAT_MAXW-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

endpackage

// File: rtl/seq_adder_digit.sv
// adder_digit: combinational DIGIT-bit ripple-carry slice.
// Zero latency; no flow control.
module adder_digit
  import seq_adder_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o
);

  logic c;

  always_comb begin
    sum_o = '0;
    c     = cin_i;
    for (int i = 0; i < DIGIT; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/seq_adder.sv
// seq_adder: WIDTH-bit add/sub, DIGIT bits per cycle LSB first; done NDIG cycles after start.
// start ignored while busy; out/flags held until next accepted start. SEQ_ADDER_SATURATE_EN clamps on overflow.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, out_q, out_d;
  logic             carry_q, carry_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

  logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
  logic             dig_cout;
  logic [WIDTH-1:0] sum_full, res;
  logic             ovf;

  assign dig_a = a_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign dig_b = b_q[int'(cnt_q)*DIGIT +: DIGIT];

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i    (dig_a),
    .b_i    (dig_b),
    .cin_i  (carry_q),
    .sum_o  (dig_sum),
    .cout_o (dig_cout)
  );

  // Full-width view of the sum including the digit being written this cycle.
  always_comb begin
    sum_full = sum_q;
    sum_full[int'(cnt_q)*DIGIT +: DIGIT] = dig_sum;
  end

  assign ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);

`ifdef SEQ_ADDER_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
  assign res = ovf ? (a_q[WIDTH-1] ? SAT_NEG : SAT_POS) : sum_full;
`else
  assign res = sum_full;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    out_d   = out_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = in1;
          b_d     = sub ? ~in2 : in2;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d   = sum_full;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          out_d   = res;
          n_d     = res[WIDTH-1];
          z_d     = (res == '0);
          c_d     = dig_cout;
          v_d     = ovf;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign out  = out_q;
  assign N    = n_q;
  assign Z    = z_q;
  assign C    = c_q;
  assign V    = v_q;

endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder: 8/2, 16/4 and 8/8 configurations side by side.
module tb_seq_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_w, start_c, sub;
  logic [15:0] in1, in2;

  logic        busy_a, done_a, n_a, z_a, c_a, v_a;
  logic [7:0]  out_a;
  logic        busy_w, done_w, n_w, z_w, c_w, v_w;
  logic [15:0] out_w;
  logic        busy_c, done_c, n_c, z_c, c_c, v_c;
  logic [7:0]  out_c;

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;

  always #5 clk = ~clk;

  seq_adder #(.WIDTH(8), .DIGIT(2)) u_dut_a (
    .clock(clk), .reset(rst_n), .start(start_a), .sub(sub), .in1(in1[7:0]), .in2(in2[7:0]),
    .busy(busy_a), .done(done_a), .out(out_a), .N(n_a), .Z(z_a), .C(c_a), .V(v_a));

  seq_adder #(.WIDTH(16), .DIGIT(4)) u_dut_w (
    .clock(clk), .reset(rst_n), .start(start_w), .sub(sub), .in1(in1), .in2(in2),
    .busy(busy_w), .done(done_w), .out(out_w), .N(n_w), .Z(z_w), .C(c_w), .V(v_w));

  seq_adder #(.WIDTH(8), .DIGIT(8)) u_dut_c (
    .clock(clk), .reset(rst_n), .start(start_c), .sub(sub), .in1(in1[7:0]), .in2(in2[7:0]),
    .busy(busy_c), .done(done_c), .out(out_c), .N(n_c), .Z(z_c), .C(c_c), .V(v_c));

  logic        o_busy, o_done;
  logic [15:0] o_out;
  logic [3:0]  o_nzcv;

  assign o_busy = (sel == 1) ? busy_w : (sel == 2) ? busy_c : busy_a;
  assign o_done = (sel == 1) ? done_w : (sel == 2) ? done_c : done_a;
  assign o_out  = (sel == 1) ? out_w  : (sel == 2) ? {8'h00, out_c} : {8'h00, out_a};
  assign o_nzcv = (sel == 1) ? {n_w, z_w, c_w, v_w} :
                  (sel == 2) ? {n_c, z_c, c_c, v_c} : {n_a, z_a, c_a, v_a};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    case (sel)
      1:       start_w = v;
      2:       start_c = v;
      default: start_a = v;
    endcase
  endtask

  // One operation: operands scrambled during RUN; optional stray start mid-run.
  task automatic run_check(input string tag, input int s, input logic subv,
                           input logic [15:0] x, input logic [15:0] y, input logic [15:0] ex,
                           input logic [3:0] enzcv, input int exp_lat, input bit poke);
    int lat, bcnt, extra;
    sel = s;
    @(negedge clk);
    sub = subv; in1 = x; in2 = y;
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    in1 = ~x; in2 = ~y; sub = ~subv;
    lat = 0; bcnt = 0;
    while (!o_done && lat < 20) begin
      if (o_busy) bcnt++;
      if (poke && lat == 2) begin
        drive_start(1'b1);
        in1 = 16'h0011; in2 = 16'h0022;
      end else begin
        drive_start(1'b0);
      end
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bcnt, exp_lat);
    check({tag, "_out"}, o_out, ex);
    check({tag, "_nzcv"}, o_nzcv, enzcv);
    check({tag, "_busy_at_done"}, o_busy, 1'b0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done) extra++;
    end
    check({tag, "_extra_done"}, extra, 0);
    check({tag, "_out_hold"}, o_out, ex);
  endtask

  logic [15:0] bx[3], by[3], bexp[3];

  initial begin
    int gap, seen;
    rst_n = 1'b0; start_a = 1'b0; start_w = 1'b0; start_c = 1'b0;
    sub = 1'b0; in1 = '0; in2 = '0;
    #12;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_out", out_a, 8'h00);
    check("rst_nzcv", {n_a, z_a, c_a, v_a}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    run_check("add_05_03", 0, 1'b0, 16'h05, 16'h03, 16'h08, 4'b0000, 4, 1'b0);
    run_check("add_ff_01", 0, 1'b0, 16'hFF, 16'h01, 16'h00, 4'b0110, 4, 1'b0);
`ifdef SEQ_ADDER_SATURATE_EN
    run_check("add_7f_01", 0, 1'b0, 16'h7F, 16'h01, 16'h7F, 4'b0001, 4, 1'b0);
`else
    run_check("add_7f_01", 0, 1'b0, 16'h7F, 16'h01, 16'h80, 4'b1001, 4, 1'b0);
`endif
    run_check("sub_03_05", 0, 1'b1, 16'h03, 16'h05, 16'hFE, 4'b1000, 4, 1'b0);
`ifdef SEQ_ADDER_SATURATE_EN
    run_check("sub_80_01", 0, 1'b1, 16'h80, 16'h01, 16'h80, 4'b1011, 4, 1'b0);
`else
    run_check("sub_80_01", 0, 1'b1, 16'h80, 16'h01, 16'h7F, 4'b0011, 4, 1'b0);
`endif
    run_check("stray_start", 0, 1'b0, 16'h05, 16'h03, 16'h08, 4'b0000, 4, 1'b1);
    run_check("w16_d4", 1, 1'b0, 16'h0005, 16'h0003, 16'h0008, 4'b0000, 4, 1'b0);
    run_check("w8_d8", 2, 1'b0, 16'h05, 16'h03, 16'h08, 4'b0000, 1, 1'b0);

    // Back-to-back: start held high, each DONE cycle accepts the next operands.
    bx[0] = 16'h10; by[0] = 16'h20; bexp[0] = 16'h30;
    bx[1] = 16'h40; by[1] = 16'h41; bexp[1] = 16'h81;
    bx[2] = 16'h01; by[2] = 16'h02; bexp[2] = 16'h03;
    sel = 0;
    @(negedge clk);
    sub = 1'b0; in1 = bx[0]; in2 = by[0]; start_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k > 0) check("b2b_handover", {o_busy, o_done}, 2'b10);
      gap = 1;
      while (!o_done && gap < 20) begin
        @(negedge clk);
        gap++;
      end
      check("b2b_interval", gap, 5);
      check("b2b_out", o_out, bexp[k]);
      check("b2b_busy_at_done", o_busy, 1'b0);
      if (k < 2) begin
        in1 = bx[k+1]; in2 = by[k+1];
      end else begin
        start_a = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a run.
    start_a = 1'b1; in1 = 16'h22; in2 = 16'h11;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy_a, 1'b0);
    check("arst_done", done_a, 1'b0);
    check("arst_out", out_a, 8'h00);
    check("arst_nzcv", {n_a, z_a, c_a, v_a}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_a || busy_a) seen++;
    end
    check("arst_no_done", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
